// File: rtl/timer_pkg.sv
// Shared constants and types for the memory-mapped countdown timer.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CTRL_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  // Field order mirrors the CTRL bit positions: im=[3], mode=[2:1], en=[0].
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_irq_source.sv
// 32-bit countdown timer with one-shot / auto-reload modes driving one CP0 interrupt line.
module timer_irq_source
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] preset_q;
  logic [DATA_W-1:0] count_q;
  logic              pend_q;
  state_e            state_q;
  logic              ctrl_wr;
  logic              preset_wr;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

  // CTRL as seen after this edge's bus write; FSM decisions use this view.
  assign ctrl_d = ctrl_wr ? ctrl_t'(wdata[CTRL_W-1:0]) : ctrl_q;

  assign irq = pend_q & ctrl_q.im;

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = DATA_W'(ctrl_q);
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      state_q  <= IDLE;
    end else begin
      ctrl_q <= ctrl_d;
      if (preset_wr) begin
        preset_q <= wdata;
      end

      case (state_q)
        IDLE: begin
          // Start is taken from the already-registered EN, so a start costs one idle cycle.
          if (ctrl_q.en && ctrl_d.en) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!ctrl_d.en) begin
            state_q <= IDLE;
          end else begin
            count_q <= preset_q;
            state_q <= CNT;
          end
        end
        CNT: begin
          if (!ctrl_d.en) begin
            state_q <= IDLE;
          end else if (count_q <= DATA_W'(1)) begin
            count_q <= '0;
            pend_q  <= 1'b1;
            state_q <= INT;
          end else begin
            count_q <= count_q - DATA_W'(1);
          end
        end
        INT: begin
          if (ctrl_d.mode == MODE_RELOAD) begin
            pend_q  <= 1'b0;
            state_q <= LOAD;
          end else begin
            // A concurrent CTRL write keeps its own EN value.
            if (!ctrl_wr) begin
              ctrl_q.en <= 1'b0;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Any CTRL write acknowledges the interrupt, overriding a same-edge set.
      if (ctrl_wr) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source.
module tb_timer_irq_source;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_LOAD = 32'd1;
  localparam logic [31:0] S_INT  = 32'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ar_cnt [2:9] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0};

  timer_irq_source dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each call starts and ends 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, 32'(irq), 32'(exp));
  endtask

  initial begin
    // Reset state
    step(2);
    reset = 1'b0;
    rd("rst_ctrl", A_CTRL, 32'd0);
    rd("rst_preset", A_PRESET, 32'd0);
    rd("rst_count", A_COUNT, 32'd0);
    rd("rst_rsvd", A_RSVD, 32'd0);
    chk_irq("rst_irq", 1'b0);
    wr(A_COUNT, 32'd5);
    rd("count_ro", A_COUNT, 32'd0);
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd("rsvd_ro", A_RSVD, 32'd0);

    // One-shot, PRESET=3
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    check("os_e0_state", 32'(dut.state_q), S_IDLE);
    step(1);
    check("os_e1_state", 32'(dut.state_q), S_LOAD);
    step(3);
    rd("os_e4_count", A_COUNT, 32'd1);
    chk_irq("os_e4_irq", 1'b0);
    step(1);
    chk_irq("os_e5_irq", 1'b1);
    check("os_e5_pend", 32'(dut.pend_q), 32'd1);
    check("os_e5_state", 32'(dut.state_q), S_INT);
    rd("os_e5_count", A_COUNT, 32'd0);
    step(1);
    check("os_e6_state", 32'(dut.state_q), S_IDLE);
    rd("os_e6_ctrl", A_CTRL, 32'h8);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_irq("os_hold_irq", 1'b1);
    end
    wr(A_CTRL, 32'h8);
    chk_irq("os_ack_irq", 1'b0);

    // Auto-reload, PRESET=2
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    step(1);
    chk_irq("ar_e1_irq", 1'b0);
    for (int k = 2; k <= 9; k++) begin
      step(1);
      rd("ar_count", A_COUNT, ar_cnt[k]);
      chk_irq("ar_irq", (k == 4) || (k == 8));
    end
    wr(A_CTRL, 32'h0);
    step(2);
    chk_irq("ar_stop_irq", 1'b0);
    check("ar_stop_state", 32'(dut.state_q), S_IDLE);

    // Masked: pend sets internally but irq stays low
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h1);
    step(3);
    check("mask_pend", 32'(dut.pend_q), 32'd1);
    chk_irq("mask_irq", 1'b0);
    step(1);
    rd("mask_ctrl_en_clr", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h8);
    check("mask_ack_pend", 32'(dut.pend_q), 32'd0);
    chk_irq("mask_ack_irq", 1'b0);

    // Pause/abort at COUNT=6, then re-enable and reload
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    step(6);
    rd("pause_pre_count", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h8);
    check("pause_state", 32'(dut.state_q), S_IDLE);
    rd("pause_count", A_COUNT, 32'd6);
    chk_irq("pause_irq", 1'b0);
    step(3);
    rd("pause_hold_count", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h9);
    step(1);
    check("reen_state", 32'(dut.state_q), S_LOAD);
    rd("reen_e1_count", A_COUNT, 32'd6);
    step(1);
    rd("reen_e2_count", A_COUNT, 32'd10);
    wr(A_PRESET, 32'd100);
    rd("midwr_count", A_COUNT, 32'd9);
    rd("midwr_preset", A_PRESET, 32'd100);
    step(1);
    rd("midwr_next_count", A_COUNT, 32'd8);
    wr(A_CTRL, 32'h0);

    // PRESET=0 behaves like 1; reset asserted while in INT
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    step(2);
    chk_irq("p0_e2_irq", 1'b0);
    rd("p0_e2_count", A_COUNT, 32'd0);
    wr(A_PRESET, 32'd7);
    chk_irq("p0_e3_irq", 1'b1);
    check("p0_e3_state", 32'(dut.state_q), S_INT);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_irq("rstint_irq", 1'b0);
    check("rstint_pend", 32'(dut.pend_q), 32'd0);
    check("rstint_state", 32'(dut.state_q), S_IDLE);
    rd("rstint_ctrl", A_CTRL, 32'd0);
    rd("rstint_preset", A_PRESET, 32'd0);
    rd("rstint_count", A_COUNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
